i2s_tdm_tx: RTL and testbench

I2S_TDM_TX -- requirements
Module: i2s_tdm_tx

---
 rtl/i2s_tdm_tx_pkg.sv | 14 +
 rtl/i2s_clk_div.sv | 40 ++++
 rtl/i2s_tdm_tx.sv | 142 ++++++++++++++
 tb/tb_i2s_tdm_tx.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_tdm_tx_pkg.sv
// Shared definitions for the I2S / TDM transmitter.
// Mode encoding and counter width helper.
package i2s_tdm_tx_pkg;

  typedef enum logic {
    MODE_I2S = 1'b0,
    MODE_LJ  = 1'b1
  } mode_e;

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/i2s_clk_div.sv
// Serial bit clock divider for the I2S / TDM transmitter.
// Emits sck plus strobes flagging the edge on which sck rises or falls.
module i2s_clk_div
  import i2s_tdm_tx_pkg::*;
#(
  parameter int SCK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_w(SCK_DIV);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = en & (cnt == CW'(SCK_DIV - 1));
  assign rise = wrap & ~sck;
  assign fall = wrap & sck;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (wrap) begin
      cnt <= '0;
      sck <= ~sck;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2s_tdm_tx.sv
// I2S / left-justified TDM serial audio transmitter.
// One-frame holding buffer feeding a frame-wide shift register.
module i2s_tdm_tx
  import i2s_tdm_tx_pkg::*;
#(
  parameter int AUDIO_DW = 8,
  parameter int SLOT_W   = 8,
  parameter int NUM_CH   = 2,
  parameter int SCK_DIV  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       lj_mode,
  input  logic [NUM_CH*AUDIO_DW-1:0] in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       sck,
  output logic                       ws,
  output logic                       sd,
  output logic                       frame_start,
  output logic                       underflow
);

  localparam int FW   = NUM_CH * SLOT_W;
  localparam int BW   = cnt_w(SLOT_W);
  localparam int SW   = cnt_w(NUM_CH);
  localparam int HALF = NUM_CH / 2;

  logic                       active;
  logic                       frame_end;
  logic                       buf_full;
  logic [NUM_CH*AUDIO_DW-1:0] buf_data;
  logic [FW-1:0]              shreg;
  logic [BW-1:0]              bit_cnt;
  logic [SW-1:0]              slot_cnt;
  mode_e                      lj_q;

  logic          div_en, rise, fall;
  logic          accept, load, step;
  logic [FW-1:0] frame_bits, sh_nxt;
  logic [BW-1:0] bit_nxt;
  logic [SW-1:0] slot_nxt;
  mode_e         mode_nxt;
  logic          ws_nxt, sd_nxt;

  assign div_en   = en & active;
  assign in_ready = ~buf_full;
  assign accept   = in_valid & ~buf_full;
  assign load     = en & (~active | (fall & frame_end));
  assign step     = en & active & fall;

  i2s_clk_div #(
    .SCK_DIV(SCK_DIV)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .en   (div_en),
    .sck  (sck),
    .rise (rise),
    .fall (fall)
  );

  // Slot-padded serial image of the buffer; empty buffer sends silence.
  always_comb begin
    frame_bits = '0;
    if (buf_full) begin
      for (int s = 0; s < NUM_CH; s++) begin
        frame_bits[FW-1-s*SLOT_W -: AUDIO_DW] =
          buf_data[s*AUDIO_DW +: AUDIO_DW];
      end
    end
  end

  always_comb begin
    mode_nxt = load ? mode_e'(lj_mode) : lj_q;
    bit_nxt  = bit_cnt + BW'(1);
    slot_nxt = slot_cnt;
    sh_nxt   = shreg << 1;
    if (load) begin
      bit_nxt  = '0;
      slot_nxt = '0;
      sh_nxt   = frame_bits;
    end else if (bit_cnt == BW'(SLOT_W - 1)) begin
      bit_nxt  = '0;
      slot_nxt = slot_cnt + SW'(1);
    end
    ws_nxt = (slot_nxt >= SW'(HALF));
    // I2S replays the bit that left the register one sck earlier.
    sd_nxt = (mode_nxt == MODE_LJ) ? sh_nxt[FW-1] : shreg[FW-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active      <= 1'b0;
      frame_end   <= 1'b0;
      buf_full    <= 1'b0;
      buf_data    <= '0;
      shreg       <= '0;
      bit_cnt     <= '0;
      slot_cnt    <= '0;
      lj_q        <= MODE_I2S;
      ws          <= 1'b0;
      sd          <= 1'b0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      frame_start <= load;
      underflow   <= load & ~buf_full;
      if (accept) begin
        buf_data <= in_data;
        buf_full <= 1'b1;
      end else if (load) begin
        buf_full <= 1'b0;
      end
      if (!en) begin
        active    <= 1'b0;
        frame_end <= 1'b0;
        shreg     <= '0;
        bit_cnt   <= '0;
        slot_cnt  <= '0;
        ws        <= 1'b0;
        sd        <= 1'b0;
      end else begin
        active <= 1'b1;
        if (rise) begin
          frame_end <= (slot_cnt == SW'(NUM_CH - 1)) &&
                       (bit_cnt == BW'(SLOT_W - 1));
        end
        if (load | step) begin
          bit_cnt  <= bit_nxt;
          slot_cnt <= slot_nxt;
          shreg    <= sh_nxt;
          lj_q     <= mode_nxt;
          ws       <= ws_nxt;
          sd       <= sd_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Bench for i2s_tdm_tx: a stereo 8-bit instance and a 4-slot 12-in-16 one.
// A bit-position reference model predicts every captured ws/sd bit.
module tb_i2s_tdm_tx;

  localparam int FR_A = 64;
  localparam int FR_B = 128;

  logic        clk = 1'b0;
  logic        rst, en, lj_mode, in_valid;
  logic [47:0] data;
  bit          sel;

  logic en_a, v_a, rdy_a, sck_a, ws_a, sd_a, fs_a, uf_a;
  logic en_b, v_b, rdy_b, sck_b, ws_b, sd_b, fs_b, uf_b;
  logic rdy, sck_m, ws_m, sd_m, fs_m, uf_m;

  assign en_a  = en & ~sel;
  assign v_a   = in_valid & ~sel;
  assign en_b  = en & sel;
  assign v_b   = in_valid & sel;
  assign rdy   = sel ? rdy_b : rdy_a;
  assign sck_m = sel ? sck_b : sck_a;
  assign ws_m  = sel ? ws_b : ws_a;
  assign sd_m  = sel ? sd_b : sd_a;
  assign fs_m  = sel ? fs_b : fs_a;
  assign uf_m  = sel ? uf_b : uf_a;

  i2s_tdm_tx dut_a (
    .clk(clk), .rst(rst), .en(en_a), .lj_mode(lj_mode),
    .in_data(data[15:0]), .in_valid(v_a), .in_ready(rdy_a),
    .sck(sck_a), .ws(ws_a), .sd(sd_a),
    .frame_start(fs_a), .underflow(uf_a)
  );

  i2s_tdm_tx #(
    .AUDIO_DW(12), .SLOT_W(16), .NUM_CH(4), .SCK_DIV(1)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .lj_mode(lj_mode),
    .in_data(data), .in_valid(v_b), .in_ready(rdy_b),
    .sck(sck_b), .ws(ws_b), .sd(sd_b),
    .frame_start(fs_b), .underflow(uf_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int t0 = 0;

  bit cap_ws[$];
  bit cap_sd[$];
  int fs_cnt = 0;
  int uf_cnt = 0;
  logic sck_p = 1'b0;

  logic [63:0] ld_q[$];
  bit          md_q[$];

  // Receiver: sample ws/sd where sck has just risen.
  always @(negedge clk) begin
    if (sck_m && !sck_p) begin
      cap_ws.push_back(ws_m);
      cap_sd.push_back(sd_m);
    end
    sck_p = sck_m;
    if (fs_m) fs_cnt++;
    if (uf_m) uf_cnt++;
  end

  function automatic int nb(int s);  return s ? 64 : 16; endfunction
  function automatic int sw(int s);  return s ? 16 : 8;  endfunction
  function automatic int adw(int s); return s ? 12 : 8;  endfunction
  function automatic int hlf(int s); return s ? 2 : 1;   endfunction
  function automatic int frc(int s); return s ? FR_B : FR_A; endfunction

  function automatic bit fbit(int s, logic [63:0] f, int p);
    int b;
    int sl;
    b  = p % sw(s);
    sl = p / sw(s);
    if (b >= adw(s)) return 1'b0;
    return f[sl*adw(s) + adw(s) - 1 - b];
  endfunction

  function automatic bit exp_sd(int s, int k);
    int m;
    int p;
    m = k / nb(s);
    p = k % nb(s);
    if (md_q[m]) return fbit(s, ld_q[m], p);
    if (p > 0) return fbit(s, ld_q[m], p - 1);
    if (m == 0) return 1'b0;
    return fbit(s, ld_q[m-1], nb(s) - 1);
  endfunction

  function automatic bit exp_ws(int s, int p);
    return (p / sw(s)) >= hlf(s);
  endfunction

  function automatic logic [15:0] word(int st, int w);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < w; i++)
      if (st + i < cap_sd.size()) r = {r[14:0], cap_sd[st+i]};
    return r;
  endfunction

  task automatic offer(input logic [47:0] d);
    int t;
    t = 0;
    data = d;
    in_valid = 1'b1;
    while (!rdy && t < 4 * FR_B) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!rdy) begin
      errors++;
      $display("FAIL offer_timeout: in_ready=%0b want 1", rdy);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic start();
    cap_ws.delete();
    cap_sd.delete();
    fs_cnt = 0;
    uf_cnt = 0;
    en = 1'b1;
    t0 = cyc;
  endtask

  task automatic wait_to(input int c);
    while (cyc < t0 + c) @(negedge clk);
  endtask

  task automatic stop();
    en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_stream(input string nm, input int uf_exp);
    int n;
    int k;
    int want_len;
    logic [63:0] a_sd, e_sd, a_ws, e_ws;
    n = nb(sel);
    want_len = (ld_q.size() - 1) * n + n / 2;
    checks++;
    if (cap_sd.size() != want_len) begin
      errors++;
      $display("FAIL %s bit_count: got %0d want %0d",
               nm, cap_sd.size(), want_len);
    end
    for (int m = 0; m < ld_q.size(); m++) begin
      a_sd = '0; e_sd = '0; a_ws = '0; e_ws = '0;
      for (int p = 0; p < n; p++) begin
        k = m * n + p;
        if (k < want_len) begin
          if (k < cap_sd.size()) begin
            a_sd[p] = cap_sd[k];
            a_ws[p] = cap_ws[k];
          end
          e_sd[p] = exp_sd(sel, k);
          e_ws[p] = exp_ws(sel, p);
        end
      end
      checks++;
      if (a_sd !== e_sd) begin
        errors++;
        $display("FAIL %s sd frame%0d: got %h want %h", nm, m, a_sd, e_sd);
      end
      checks++;
      if (a_ws !== e_ws) begin
        errors++;
        $display("FAIL %s ws frame%0d: got %h want %h", nm, m, a_ws, e_ws);
      end
    end
    checks++;
    if (fs_cnt != ld_q.size()) begin
      errors++;
      $display("FAIL %s frame_start: got %0d want %0d",
               nm, fs_cnt, ld_q.size());
    end
    checks++;
    if (uf_cnt != uf_exp) begin
      errors++;
      $display("FAIL %s underflow: got %0d want %0d", nm, uf_cnt, uf_exp);
    end
  endtask

  task automatic check_idle(input string nm, input logic want_rdy);
    checks++;
    if ({sck_m, ws_m, sd_m, fs_m, uf_m} !== 5'b0) begin
      errors++;
      $display("FAIL %s outputs: got %b want 00000", nm,
               {sck_m, ws_m, sd_m, fs_m, uf_m});
    end
    checks++;
    if (rdy !== want_rdy) begin
      errors++;
      $display("FAIL %s in_ready: got %b want %b", nm, rdy, want_rdy);
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check_idle("reset", 1'b1);
    end
    sel = 1'b0;
  endtask

  task automatic test_i2s_underflow();
    sel = 1'b0;
    lj_mode = 1'b0;
    offer(48'h3CA5);
    start();
    ld_q = '{64'h3CA5, 64'h0};
    md_q = '{1'b0, 1'b0};
    wait_to(FR_A + FR_A / 2);
    stop();
    check_stream("i2s", 1);
    checks++;
    if (word(1, 8) !== 16'h00A5 || cap_ws[1] !== 1'b0) begin
      errors++;
      $display("FAIL i2s_left: got %h ws %b want a5 ws 0",
               word(1, 8), cap_ws[1]);
    end
    checks++;
    if (word(9, 8) !== 16'h003C || cap_ws[9] !== 1'b1) begin
      errors++;
      $display("FAIL i2s_right: got %h ws %b want 3c ws 1",
               word(9, 8), cap_ws[9]);
    end
  endtask

  task automatic test_lj();
    sel = 1'b0;
    lj_mode = 1'b1;
    offer(48'h3CA5);
    start();
    ld_q = '{64'h3CA5, 64'h0};
    md_q = '{1'b1, 1'b1};
    wait_to(FR_A + FR_A / 2);
    stop();
    check_stream("lj", 1);
    checks++;
    if (word(0, 8) !== 16'h00A5 || word(8, 8) !== 16'h003C) begin
      errors++;
      $display("FAIL lj_words: got %h %h want a5 3c",
               word(0, 8), word(8, 8));
    end
  endtask

  task automatic test_tdm4();
    sel = 1'b1;
    lj_mode = 1'b1;
    offer(48'h789456123ABC);
    start();
    ld_q = '{64'h789456123ABC, 64'h0};
    md_q = '{1'b1, 1'b1};
    wait_to(FR_B + FR_B / 2);
    stop();
    check_stream("tdm4", 1);
    checks++;
    if ({word(0, 16), word(16, 16), word(32, 16), word(48, 16)}
        !== 64'hABC0_1230_4560_7890) begin
      errors++;
      $display("FAIL tdm4_slots: got %h %h %h %h want abc0 1230 4560 7890",
               word(0, 16), word(16, 16), word(32, 16), word(48, 16));
    end
    sel = 1'b0;
  endtask

  task automatic test_random(input bit s);
    logic [47:0] f[4];
    logic [47:0] mask;
    bit m0, m1;
    int fr;
    sel = s;
    fr = frc(s);
    mask = s ? 48'hFFFF_FFFF_FFFF : 48'h0000_0000_FFFF;
    m0 = 1'($urandom_range(1));
    m1 = 1'($urandom_range(1));
    ld_q.delete();
    for (int i = 0; i < 4; i++) begin
      f[i] = 48'({$urandom, $urandom}) & mask;
      ld_q.push_back(64'(f[i]));
    end
    md_q = '{m0, m0, m1, m1};
    lj_mode = m0;
    offer(f[0]);
    start();
    offer(f[1]);
    offer(f[2]);
    wait_to(fr + fr / 2);
    lj_mode = m1;
    offer(f[3]);
    wait_to(3 * fr + fr / 2);
    stop();
    check_stream(s ? "rand_tdm4" : "rand_stereo", 0);
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    lj_mode = 1'b0;
    offer(48'h5A96);
    start();
    ld_q = '{64'h5A96, 64'h0, 64'hC31E};
    md_q = '{1'b0, 1'b0, 1'b0};
    wait_to(FR_A);
    data = 48'hC31E;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (rdy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_after: got %b want 0", rdy);
    end
    wait_to(2 * FR_A);
    checks++;
    if (rdy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_hold: got %b want 0", rdy);
    end
    @(negedge clk);
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_rise: got %b want 1", rdy);
    end
    wait_to(2 * FR_A + FR_A / 2);
    stop();
    check_stream("b2b", 1);
  endtask

  task automatic test_rst_mid();
    sel = 1'b0;
    lj_mode = 1'b0;
    offer(48'h1234);
    start();
    offer(48'h9876);
    wait_to(13 * 4 + 2);
    rst = 1'b1;
    en = 1'b0;
    #1;
    check_idle("rst_mid", 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    offer(48'hE71B);
    start();
    ld_q = '{64'hE71B, 64'h0};
    md_q = '{1'b0, 1'b0};
    wait_to(FR_A + FR_A / 2);
    stop();
    check_stream("rst_restart", 1);
  endtask

  task automatic test_en_drop();
    sel = 1'b0;
    lj_mode = 1'b1;
    offer(48'h0F0F);
    start();
    offer(48'h6DB2);
    wait_to(FR_A / 2);
    en = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("en_drop", 1'b0);
    start();
    ld_q = '{64'h6DB2, 64'h0};
    md_q = '{1'b1, 1'b1};
    wait_to(FR_A + FR_A / 2);
    stop();
    check_stream("en_resume", 1);
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    lj_mode = 1'b0;
    in_valid = 1'b0;
    data = '0;
    sel = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_i2s_underflow();
    test_lj();
    test_tdm4();
    test_random(1'b0);
    test_random(1'b1);
    test_back_to_back();
    test_rst_mid();
    test_en_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
